// File: rtl/dft_octave_scheduler.sv
// dft_octave_scheduler: per-sample top-octave pass plus one ruler-sequence secondary octave pass
module dft_octave_scheduler #(
   parameter int OC  = 5,
   parameter int BPO = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sampleReady,
   output logic                   ready,
   output logic [OC-1:0]          writeMask,
   output logic                   doCalculations,
   output logic [$clog2(OC)-1:0]  octave,
   output logic                   operation,
   output logic [$clog2(BPO)-1:0] bin,
   output logic                   finishedProcessing,
   output logic [OC-2:0]          phase,
   output logic [7:0]             dropCount
);
   localparam int OW = $clog2(OC);
   localparam int BW = $clog2(BPO);
   localparam int PW = OC - 1;
   typedef enum logic [2:0] {ST_WAIT, ST_WRITE, ST_SUB, ST_ADD, ST_DONE} state_t;
   state_t        state_q, state_d;
   logic          pass_q, pass_d;
   logic [BW-1:0] bin_q, bin_d;
   logic [OW-1:0] octave_q, octave_d, sec;
   logic [PW-1:0] phase_q, phase_d;
   logic [7:0]    drop_q, drop_d;
   logic          has_sec, last_bin;
   always_comb begin
      sec = '0;
      for (int i = PW - 1; i >= 0; i--) if (phase_q[i]) sec = OW'(i + 1);
      has_sec  = |phase_q;
      last_bin = bin_q == BW'(BPO - 1);
      state_d  = state_q;
      pass_d   = pass_q;
      bin_d    = bin_q;
      octave_d = octave_q;
      phase_d  = phase_q;
      drop_d   = (sampleReady && state_q != ST_WAIT && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
      case (state_q)
         ST_WAIT: if (sampleReady) state_d = ST_WRITE;
         ST_WRITE: begin
            pass_d   = 1'b0;
            bin_d    = '0;
            octave_d = '0;
            state_d  = ST_SUB;
         end
         ST_SUB: begin
            bin_d = last_bin ? '0 : bin_q + 1'b1;
            if (last_bin) state_d = ST_ADD;
         end
         ST_ADD: begin
            bin_d = last_bin ? '0 : bin_q + 1'b1;
            if (last_bin) begin
               if (!pass_q && has_sec) begin
                  pass_d   = 1'b1;
                  octave_d = sec;
                  state_d  = ST_SUB;
               end else begin
                  octave_d = '0;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            phase_d = phase_q + 1'b1;
            pass_d  = 1'b0;
            state_d = ST_WAIT;
         end
         default: state_d = ST_WAIT;
      endcase
      writeMask = '0;
      if (state_q == ST_WRITE) begin
         writeMask[0] = 1'b1;
         if (has_sec) writeMask[sec] = 1'b1;
      end
      ready              = state_q == ST_WAIT;
      operation          = state_q == ST_ADD;
      doCalculations     = state_q == ST_SUB || state_q == ST_ADD;
      finishedProcessing = state_q == ST_DONE;
      octave             = octave_q;
      bin                = bin_q;
      phase              = phase_q;
      dropCount          = drop_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_WAIT;
         pass_q   <= 1'b0;
         bin_q    <= '0;
         octave_q <= '0;
         phase_q  <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         pass_q   <= pass_d;
         bin_q    <= bin_d;
         octave_q <= octave_d;
         phase_q  <= phase_d;
         drop_q   <= drop_d;
      end
   end
endmodule
